// File: rtl/slide_sched.sv
// slide_sched: turns a signed-digit window array into a serial stream of
// DBL / ADD / SUB commands for the point-operation engine, MSB first.
module slide_sched #(
  parameter int NDIG = 256,
  parameter int DW   = 8,
  parameter int IDXW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [NDIG*DW-1:0] r,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [IDXW-1:0]    cmd_idx,
  output logic               cmd_last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_DBL = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_SUB = 2'd3;

  localparam logic signed [DW:0] DMAX = (DW+1)'(15);
  localparam logic signed [DW:0] DMIN = -DMAX;

  typedef enum logic [2:0] {IDLE, SCAN, ADDSUB, DBL, DONE} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         i, i_nxt;
  logic [DW-1:0]         digits [NDIG];
  logic signed [DW-1:0]  d_cur;
  logic                  d_nz;
  logic                  i_zero;
  logic                  load;
  logic                  err_set;

  // Table index is |d|>>1; the magnitude is formed one bit wider so -2^(DW-1) is exact.
  function automatic logic [IDXW-1:0] tbl_idx(input logic signed [DW-1:0] d);
    logic signed [DW:0] dx;
    logic [DW:0]        mag;
    dx  = {d[DW-1], d};
    mag = dx[DW] ? -dx : dx;
    return mag[IDXW:1];
  endfunction

  // A legal window digit is zero or odd with magnitude at most 15.
  function automatic logic digit_illegal(input logic signed [DW-1:0] d);
    logic signed [DW:0] dx;
    dx = {d[DW-1], d};
    return (dx != '0) && (!dx[0] || (dx > DMAX) || (dx < DMIN));
  endfunction

  assign d_cur  = digits[i];
  assign d_nz   = (d_cur != '0);
  assign i_zero = (i == '0);

  // State and digit-position register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      i     <= '0;
    end else begin
      state <= state_nxt;
      i     <= i_nxt;
    end
  end

  // Digit array captured on an accepted start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NDIG; k++) digits[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NDIG; k++) digits[k] <= r[k*DW +: DW];
    end
  end

  // Sticky illegal-digit flag, cleared when a new scalar is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (load)    err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Next-state logic: scan past leading zeros, then alternate DBL and ADD/SUB.
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    load      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          load      = 1'b1;
          i_nxt     = IW'(NDIG-1);
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (d_nz) begin
          state_nxt = ADDSUB;
          err_set   = digit_illegal(d_cur);
        end else if (i_zero) begin
          state_nxt = DONE;
        end else begin
          i_nxt = i - 1'b1;
        end
      end
      ADDSUB: begin
        if (cmd_ready) begin
          if (i_zero) begin
            state_nxt = DONE;
          end else begin
            i_nxt     = i - 1'b1;
            state_nxt = DBL;
          end
        end
      end
      DBL: begin
        if (cmd_ready) begin
          if (d_nz) begin
            state_nxt = ADDSUB;
            err_set   = digit_illegal(d_cur);
          end else if (i_zero) begin
            state_nxt = DONE;
          end else begin
            i_nxt = i - 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command outputs decoded from registered state and digit only.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_idx   = '0;
    cmd_last  = 1'b0;
    case (state)
      ADDSUB: begin
        cmd_valid = 1'b1;
        cmd_op    = d_cur[DW-1] ? OP_SUB : OP_ADD;
        cmd_idx   = tbl_idx(d_cur);
        cmd_last  = i_zero;
      end
      DBL: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_DBL;
        cmd_last  = i_zero && !d_nz;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_slide_sched.sv
// Testbench for slide_sched: directed scenarios plus randomized scalars,
// checked against a double-and-add command model built from the digit array.
module tb_slide_sched;

  localparam int NDIG = 256;
  localparam int DW   = 8;
  localparam int IDXW = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               valid = 1'b0;
  logic [NDIG*DW-1:0] r = '0;
  logic               cmd_ready = 1'b0;
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [IDXW-1:0]    cmd_idx;
  logic               cmd_last;
  logic               busy;
  logic               done;
  logic               err;

  slide_sched #(.NDIG(NDIG), .DW(DW), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .r(r),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_last(cmd_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  int exp_op[$], exp_idx[$], exp_last[$];
  int exp_t;
  bit exp_err;
  int got_op[$], got_idx[$], got_last[$];
  int first_cyc, done_cyc;

  function automatic int digit_of(input logic [NDIG*DW-1:0] rv, input int j);
    logic signed [DW-1:0] s;
    s = rv[j*DW +: DW];
    return int'(s);
  endfunction

  function automatic logic [NDIG*DW-1:0] put(input logic [NDIG*DW-1:0] rv, input int j, input int v);
    logic [NDIG*DW-1:0] o;
    o = rv;
    o[j*DW +: DW] = DW'(v);
    return o;
  endfunction

  // Reference: Horner-style double-and-add from the top nonzero digit down.
  function automatic void build_model(input logic [NDIG*DW-1:0] rv);
    int d, mag;
    exp_op.delete(); exp_idx.delete(); exp_last.delete();
    exp_t = -1;
    exp_err = 1'b0;
    for (int j = NDIG-1; j >= 0; j--) begin
      d = digit_of(rv, j);
      if (d != 0 && exp_t < 0) exp_t = j;
      if (exp_t >= 0) begin
        if (j < exp_t) begin
          exp_op.push_back(1); exp_idx.push_back(0); exp_last.push_back(0);
        end
        if (d != 0) begin
          mag = (d < 0) ? -d : d;
          exp_op.push_back(d > 0 ? 2 : 3);
          exp_idx.push_back((mag / 2) % 8);
          exp_last.push_back(0);
          if ((d % 2 == 0) || d > 15 || d < -15) exp_err = 1'b1;
        end
      end
    end
    if (exp_last.size() > 0) exp_last[exp_last.size()-1] = 1;
  endfunction

  task automatic start(input logic [NDIG*DW-1:0] rv);
    @(negedge clk);
    r = rv;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Runs one scalar to completion and compares the observed stream to the model.
  task automatic run_stream(input string name, input logic [NDIG*DW-1:0] rv,
                            input int rmode, input bit mid_valid);
    bit busy_bad, stab_bad, prev_stall;
    logic [1:0] p_op;
    logic [IDXW-1:0] p_idx;
    logic p_last;
    int n;
    build_model(rv);
    got_op.delete(); got_idx.delete(); got_last.delete();
    first_cyc = -1; done_cyc = -1;
    busy_bad = 0; stab_bad = 0; prev_stall = 0;
    p_op = '0; p_idx = '0; p_last = 1'b0;
    cmd_ready = 1'b0;
    start(rv);
    for (int cyc = 1; cyc <= 1500 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (mid_valid && cyc == 3) begin valid = 1'b1; r = ~rv; end
      else if (mid_valid && cyc == 4) begin valid = 1'b0; r = rv; end
      cmd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1, 0));
      if (cyc == 1) begin
        total++;
        if (err !== 1'b0) $display("FAIL %s err_cleared_on_valid: got %b want 0", name, err);
        else passed++;
      end
      if (prev_stall && (cmd_valid !== 1'b1 || cmd_op !== p_op || cmd_idx !== p_idx || cmd_last !== p_last))
        stab_bad = 1;
      if (busy !== 1'b1) busy_bad = 1;
      if (cmd_valid === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (cmd_ready) begin
          got_op.push_back(int'(cmd_op)); got_idx.push_back(int'(cmd_idx)); got_last.push_back(int'(cmd_last));
        end
      end
      prev_stall = (cmd_valid === 1'b1) && !cmd_ready;
      p_op = cmd_op; p_idx = cmd_idx; p_last = cmd_last;
      if (done === 1'b1) done_cyc = cyc;
    end
    total++;
    if (done_cyc < 0) $display("FAIL %s timeout: no done within 1500 cycles", name);
    else passed++;
    total++;
    if (got_op.size() !== exp_op.size()) $display("FAIL %s cmd_count: got %0d want %0d", name, got_op.size(), exp_op.size());
    else passed++;
    n = (got_op.size() < exp_op.size()) ? got_op.size() : exp_op.size();
    for (int k = 0; k < n; k++) begin
      total++;
      if (got_op[k] !== exp_op[k] || got_idx[k] !== exp_idx[k] || got_last[k] !== exp_last[k])
        $display("FAIL %s cmd[%0d]: got op%0d idx%0d last%0d want op%0d idx%0d last%0d", name, k,
                 got_op[k], got_idx[k], got_last[k], exp_op[k], exp_idx[k], exp_last[k]);
      else passed++;
    end
    if (exp_t >= 0) begin
      total++;
      if (first_cyc !== NDIG + 1 - exp_t) $display("FAIL %s first_cmd_cycle: got %0d want %0d", name, first_cyc, NDIG + 1 - exp_t);
      else passed++;
    end
    if (rmode == 0) begin
      total++;
      if (done_cyc !== ((exp_t >= 0) ? NDIG + 1 - exp_t + exp_op.size() : NDIG + 1))
        $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc,
                 (exp_t >= 0) ? NDIG + 1 - exp_t + exp_op.size() : NDIG + 1);
      else passed++;
    end
    total++;
    if (busy_bad || stab_bad) $display("FAIL %s busy_or_stall_hold: busy_bad=%0d stab_bad=%0d want 0 0", name, busy_bad, stab_bad);
    else passed++;
    total++;
    if (err !== exp_err) $display("FAIL %s err: got %b want %b", name, err, exp_err);
    else passed++;
    cmd_ready = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s done_pulse_end: done=%b busy=%b want 0 0", name, done, busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_valid, cmd_op, cmd_idx, cmd_last, busy, done, err} !== '0)
      $display("FAIL reset_outputs: got %b want 0", {cmd_valid, cmd_op, cmd_idx, cmd_last, busy, done, err});
    else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_lsb();
    run_stream("single_lsb", put('0, 0, 1), 0, 0);
    total++;
    if (got_op.size() != 1 || got_op[0] !== 2 || got_idx[0] !== 0 || got_last[0] !== 1)
      $display("FAIL single_lsb_literal: got %0d cmds want one ADD idx0 last", got_op.size());
    else passed++;
  endtask

  task automatic test_two_digits(input int rmode, input string name);
    run_stream(name, put(put('0, 2, -3), 0, 5), rmode, 0);
    total++;
    if (got_op.size() != 4 || got_op[0] !== 3 || got_idx[0] !== 1 || got_op[1] !== 1 ||
        got_op[2] !== 1 || got_op[3] !== 2 || got_idx[3] !== 2 || got_last[3] !== 1)
      $display("FAIL %s_literal: got %0d cmds want SUB1 DBL DBL ADD2", name, got_op.size());
    else passed++;
  endtask

  task automatic test_all_zero();
    run_stream("all_zero", '0, 0, 0);
  endtask

  task automatic test_top_digit_mid_valid();
    run_stream("top_digit", put(put('0, NDIG-1, 15), 0, -1), 0, 1);
    total++;
    if (first_cyc !== 2) $display("FAIL top_digit_latency: got %0d want 2", first_cyc);
    else passed++;
  endtask

  task automatic test_err_reset();
    bit seen;
    run_stream("illegal_full", put(put('0, 5, 2), 3, -128), 0, 0);
    total++;
    if (err !== 1'b1) $display("FAIL err_sticky_idle: got %b want 1", err);
    else passed++;
    run_stream("legal_after_err", put('0, 1, 7), 2, 0);
    cmd_ready = 1'b0;
    start(put('0, 5, 2));
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) seen = 1;
    end
    total++;
    if (!seen || cmd_op !== 2'd2 || cmd_idx !== 3'd1 || err !== 1'b1)
      $display("FAIL err_cmd: seen=%0d op=%0d idx=%0d err=%b want 1 2 1 1", seen, cmd_op, cmd_idx, err);
    else passed++;
    cmd_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (cmd_op !== 2'd1 || cmd_valid !== 1'b1) $display("FAIL err_dbl: op=%0d valid=%b want 1 1", cmd_op, cmd_valid);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({cmd_valid, cmd_op, cmd_idx, cmd_last, busy, done, err} !== '0)
      $display("FAIL midstream_reset: got %b want 0", {cmd_valid, cmd_op, cmd_idx, cmd_last, busy, done, err});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    total++;
    if (seen) $display("FAIL no_done_after_reset: done/busy went high want 0");
    else passed++;
    cmd_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [NDIG*DW-1:0] rv;
    int v;
    for (int it = 0; it < 4; it++) begin
      rv = '0;
      for (int j = 0; j < NDIG - 60 * it; j++) begin
        if ($urandom_range(3, 0) == 0) begin
          v = 2 * int'($urandom_range(7, 0)) + 1;
          if ($urandom_range(1, 0) == 1) v = -v;
          rv = put(rv, j, v);
        end
      end
      run_stream($sformatf("random%0d", it), rv, 2, 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_lsb();
    test_two_digits(0, "two_digits");
    test_two_digits(1, "two_digits_stall");
    test_all_zero();
    test_top_digit_mid_valid();
    test_err_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
